// File: rtl/goertzel_fsk_detector.sv
`default_nettype none
// ============================================================================
//  Module   : goertzel_fsk_detector
//  Purpose  : Three-bin Goertzel detector for a three-tone FSK receiver.
//             Runs bins k=1/5/10 in parallel over blocks of N_SAMPLES
//             samples, computes each bin power through one shared
//             multiplier set, and reports the strongest bin and whether it
//             clears THRESHOLD.
//  Ports    : clk            - sample clock
//             rst            - synchronous active-high reset
//             is14_sample    - signed 14-bit ADC sample
//             i_sample_valid - sample qualifier
//             o2_tone        - winning bin index (0=k1, 1=k5, 2=k10)
//             o_detect       - winning bin power > THRESHOLD
//             o_result_valid - one-cycle strobe with each new result
//  Revision : 1.0 - initial release
// ============================================================================
module goertzel_fsk_detector #(
    parameter int                 N_SAMPLES = 64,
    parameter logic signed [17:0] COEF0     = 18'sd32610,
    parameter logic signed [17:0] COEF1     = 18'sd28899,
    parameter logic signed [17:0] COEF2     = 18'sd18205,
    parameter int                 SW        = 32,
    parameter int                 PSHIFT    = 8,
    parameter logic [47:0]        THRESHOLD = 48'd1000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [13:0] is14_sample,
    input  logic               i_sample_valid,
    output logic [1:0]         o2_tone,
    output logic               o_detect,
    output logic               o_result_valid
);

    localparam int CW = $clog2(N_SAMPLES);
    // Wide enough that coef*a*b never overflows before the Q2.14 shift.
    localparam int PW = 2 * SW + 19;
    localparam logic signed [17:0] c_coef [3] = '{COEF0, COEF1, COEF2};

    typedef enum logic [2:0] {
        ST_ACC    = 3'd0,
        ST_PWR0   = 3'd1,
        ST_PWR1   = 3'd2,
        ST_PWR2   = 3'd3,
        ST_DECIDE = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Sample counter and block boundary
    // ------------------------------------------------------------------
    logic [CW-1:0]        r_count;
    logic                 w_last;
    logic signed [SW-1:0] w_x;

    assign w_last = i_sample_valid && (r_count == CW'(N_SAMPLES - 1));
    assign w_x    = SW'(is14_sample);

    // Power of two block length, so natural wrap gives 0..N_SAMPLES-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_sample_valid) begin
            r_count <= r_count + CW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Goertzel recursions, one per bin
    // ------------------------------------------------------------------
    logic signed [SW-1:0] w_snap1 [3];
    logic signed [SW-1:0] w_snap2 [3];

    for (genvar gi = 0; gi < 3; gi++) begin : g_bin
        logic signed [SW-1:0]    r_s1;
        logic signed [SW-1:0]    r_s2;
        logic signed [SW-1:0]    r_snap1;
        logic signed [SW-1:0]    r_snap2;
        logic signed [SW+17:0]   w_prod;
        logic signed [SW-1:0]    w_s0;

        assign w_prod = (SW+18)'(c_coef[gi]) * (SW+18)'(r_s1);
        // Truncation back to SW bits gives the mod 2^SW wrap.
        assign w_s0   = w_x + SW'(w_prod >>> 14) - r_s2;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_s1    <= '0;
                r_s2    <= '0;
                r_snap1 <= '0;
                r_snap2 <= '0;
            end else if (i_sample_valid) begin
                if (w_last) begin
                    // Capture the final states and restart with zero
                    // history so the next sample opens a fresh block.
                    r_snap1 <= w_s0;
                    r_snap2 <= r_s1;
                    r_s1    <= '0;
                    r_s2    <= '0;
                end else begin
                    r_s1    <= w_s0;
                    r_s2    <= r_s1;
                end
            end
        end

        assign w_snap1[gi] = r_snap1;
        assign w_snap2[gi] = r_snap2;
    end

    // ------------------------------------------------------------------
    // Power phase sequencer
    // ------------------------------------------------------------------
    state_t     r_state;
    state_t     w_next;
    logic [1:0] w_sel;
    logic       w_pwr_en;
    logic       w_decide;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ACC;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_sel    = 2'd0;
        w_pwr_en = 1'b0;
        w_decide = 1'b0;
        case (r_state)
            ST_ACC: begin
                if (w_last) begin
                    w_next = ST_PWR0;
                end
            end
            ST_PWR0: begin
                w_sel    = 2'd0;
                w_pwr_en = 1'b1;
                w_next   = ST_PWR1;
            end
            ST_PWR1: begin
                w_sel    = 2'd1;
                w_pwr_en = 1'b1;
                w_next   = ST_PWR2;
            end
            ST_PWR2: begin
                w_sel    = 2'd2;
                w_pwr_en = 1'b1;
                w_next   = ST_DECIDE;
            end
            ST_DECIDE: begin
                w_decide = 1'b1;
                w_next   = ST_ACC;
            end
            default: begin
                w_next = ST_ACC;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Shared power datapath: P = a^2 + b^2 - (c*a*b >>> 14)
    // ------------------------------------------------------------------
    logic signed [SW-1:0] w_a;
    logic signed [SW-1:0] w_b;
    logic signed [17:0]   w_c;
    logic signed [PW-1:0] w_ax;
    logic signed [PW-1:0] w_bx;
    logic signed [PW-1:0] w_cx;
    logic signed [PW-1:0] w_pfull;
    logic [47:0]          w_pclamp;

    always_comb begin
        w_a = w_snap1[0];
        w_b = w_snap2[0];
        w_c = c_coef[0];
        case (w_sel)
            2'd1: begin
                w_a = w_snap1[1];
                w_b = w_snap2[1];
                w_c = c_coef[1];
            end
            2'd2: begin
                w_a = w_snap1[2];
                w_b = w_snap2[2];
                w_c = c_coef[2];
            end
            default: begin
            end
        endcase
    end

    assign w_ax    = PW'(w_a >>> PSHIFT);
    assign w_bx    = PW'(w_b >>> PSHIFT);
    assign w_cx    = PW'(w_c);
    assign w_pfull = w_ax * w_ax + w_bx * w_bx - ((w_cx * w_ax * w_bx) >>> 14);

    // Negative results come only from coefficient rounding; anything past
    // the positive 48-bit range pins at the maximum.
    always_comb begin
        if (w_pfull[PW-1]) begin
            w_pclamp = '0;
        end else if (|w_pfull[PW-2:47]) begin
            w_pclamp = {1'b0, {47{1'b1}}};
        end else begin
            w_pclamp = w_pfull[47:0];
        end
    end

    logic [47:0] r_p0;
    logic [47:0] r_p1;
    logic [47:0] r_p2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_p0 <= '0;
            r_p1 <= '0;
            r_p2 <= '0;
        end else if (w_pwr_en) begin
            case (w_sel)
                2'd0:    r_p0 <= w_pclamp;
                2'd1:    r_p1 <= w_pclamp;
                default: r_p2 <= w_pclamp;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Decision: argmax with ties resolved toward the lower index
    // ------------------------------------------------------------------
    logic [1:0]  w_win;
    logic [47:0] w_pwin;

    always_comb begin
        w_win  = 2'd0;
        w_pwin = r_p0;
        if (r_p1 > w_pwin) begin
            w_win  = 2'd1;
            w_pwin = r_p1;
        end
        if (r_p2 > w_pwin) begin
            w_win  = 2'd2;
            w_pwin = r_p2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o2_tone        <= 2'd0;
            o_detect       <= 1'b0;
            o_result_valid <= 1'b0;
        end else begin
            o_result_valid <= w_decide;
            if (w_decide) begin
                o2_tone  <= w_win;
                o_detect <= (w_pwin > THRESHOLD);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_goertzel_fsk_detector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_goertzel_fsk_detector
//  Purpose  : Self-checking bench for goertzel_fsk_detector. Directed tone,
//             silence, gapped-valid and reset scenarios followed by random
//             noisy tone blocks, all scored against a block-level reference.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_goertzel_fsk_detector;

    localparam int N = 64;

    logic              clk;
    logic              rst;
    logic signed [13:0] is14_sample;
    logic              i_sample_valid;
    logic [1:0]        o2_tone;
    logic              o_detect;
    logic              o_result_valid;

    goertzel_fsk_detector dut (
        .clk            (clk),
        .rst            (rst),
        .is14_sample    (is14_sample),
        .i_sample_valid (i_sample_valid),
        .o2_tone        (o2_tone),
        .o_detect       (o_detect),
        .o_result_valid (o_result_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference: whole-block Goertzel evaluated with plain arithmetic
    // ------------------------------------------------------------------
    function automatic void ref_block(input int xs[$], output logic [1:0] tone, output logic det);
        longint coef [3];
        longint pw [3];
        longint best;
        int s0, s1, s2;
        logic signed [127:0] a, b, c, p;
        coef[0] = 32610;
        coef[1] = 28899;
        coef[2] = 18205;
        for (int k = 0; k < 3; k++) begin
            s1 = 0;
            s2 = 0;
            for (int n = 0; n < xs.size(); n++) begin
                s0 = int'(longint'(xs[n]) + ((coef[k] * longint'(s1)) >>> 14) - longint'(s2));
                s2 = s1;
                s1 = s0;
            end
            a = s1 >>> 8;
            b = s2 >>> 8;
            c = coef[k];
            p = a * a + b * b - ((c * a * b) >>> 14);
            if (p < 0)
                pw[k] = 0;
            else if (p > 128'sd140737488355327)
                pw[k] = 64'sd140737488355327;
            else
                pw[k] = longint'(p);
        end
        tone = 2'd0;
        best = pw[0];
        if (pw[1] > best) begin tone = 2'd1; best = pw[1]; end
        if (pw[2] > best) begin tone = 2'd2; best = pw[2]; end
        det = (best > 1000000);
    endfunction

    typedef struct {
        int         cyc;
        logic [1:0] tone;
        logic       det;
    } exp_t;

    int   cyc = 0;
    int   blk[$];
    exp_t exp_q[$];
    logic [1:0] hold_tone = 2'd0;
    logic       hold_det  = 1'b0;

    // Track accepted samples; every full block schedules its result four
    // edges after the edge that accepted its last sample.
    always @(posedge clk) begin
        logic [1:0] t;
        logic       d;
        cyc++;
        if (rst) begin
            blk.delete();
            exp_q.delete();
            hold_tone = 2'd0;
            hold_det  = 1'b0;
        end else if (i_sample_valid) begin
            blk.push_back(int'(is14_sample));
            if (blk.size() == N) begin
                ref_block(blk, t, d);
                exp_q.push_back('{cyc + 4, t, d});
                blk.delete();
            end
        end
    end

    always @(posedge clk) begin
        logic strobe;
        exp_t e;
        #1;
        strobe = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
        check_eq("result_valid", {63'd0, o_result_valid}, {63'd0, strobe});
        if (strobe) begin
            e = exp_q.pop_front();
            hold_tone = e.tone;
            hold_det  = e.det;
        end
        check_eq("tone", {62'd0, o2_tone}, {62'd0, hold_tone});
        check_eq("detect", {63'd0, o_detect}, {63'd0, hold_det});
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    function automatic int tone_val(input int k, input int n, input int amp);
        return int'(real'(amp) * $sin(2.0 * 3.14159265358979 * real'(k) * real'(n) / 64.0));
    endfunction

    function automatic int clamp14(input int v);
        if (v > 8191) return 8191;
        if (v < -8192) return -8192;
        return v;
    endfunction

    task automatic drive(input int x, input bit v);
        @(negedge clk);
        is14_sample    = 14'(x);
        i_sample_valid = v;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++)
            drive(int'($urandom_range(16383)) - 8192, 1'b0);
    endtask

    task automatic send_tone(input int k, input bit gapped);
        for (int n = 0; n < N; n++) begin
            drive(tone_val(k, n, 8191), 1'b1);
            if (gapped) drive(int'($urandom_range(16383)) - 8192, 1'b0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst            = 1'b1;
        i_sample_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic random_block();
        int k, amp, n, sel;
        sel = int'($urandom_range(2));
        k   = (sel == 0) ? 1 : ((sel == 1) ? 5 : 10);
        amp = int'($urandom_range(8191, 500));
        n   = 0;
        while (n < N) begin
            if ($urandom_range(3) != 0) begin
                drive(clamp14(tone_val(k, n, amp) + int'($urandom_range(600)) - 300), 1'b1);
                n++;
            end else begin
                drive(int'($urandom_range(16383)) - 8192, 1'b0);
            end
        end
    endtask

    initial begin
        rst            = 1'b1;
        i_sample_valid = 1'b0;
        is14_sample    = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // single k=5 block
        send_tone(5, 1'b0);
        idle(8);
        // back-to-back k=1 then k=10
        send_tone(1, 1'b0);
        send_tone(10, 1'b0);
        idle(8);
        // silence
        for (int n = 0; n < N; n++) drive(0, 1'b1);
        idle(8);
        // gapped valid
        send_tone(10, 1'b1);
        idle(8);
        // reset mid-block
        for (int n = 0; n < 30; n++) drive(tone_val(5, n, 8191), 1'b1);
        do_reset();
        send_tone(1, 1'b0);
        idle(8);
        // reset during power phase: rst sampled two edges after sample 63
        send_tone(10, 1'b0);
        idle(8);
        send_tone(5, 1'b0);
        drive(0, 1'b0);
        do_reset();
        send_tone(10, 1'b0);
        idle(8);
        // randomized noisy tone blocks with random valid gaps
        repeat (8) random_block();
        idle(10);

        check_eq("pending_results", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/goertzel_fsk_detector.md
Name: goertzel_fsk_detector

Overview:
Receive-side counterpart of the three-tone FSK modulator. It takes signed 14-bit ADC samples, runs three Goertzel filters in parallel over fixed blocks of N_SAMPLES samples, and computes the power of each bin. Per block, it reports which of the three tones (DDS steps 1, 5 and 10 of a 64-entry table, bins k=1/5/10 at N=64) is strongest, and whether that tone exceeds a detection threshold. It sits between the ZMOD ADC driver and downstream symbol logic, on the 100 MHz sample clock.

Parameters:
N_SAMPLES, 64, samples per Goertzel block (power of two, 8..1024)
COEF0, 32610, 2cos(2π·1/64) in signed Q2.14 (18-bit); bin 0
COEF1, 28899, 2cos(2π·5/64) in Q2.14; bin 1
COEF2, 18205, 2cos(2π·10/64) in Q2.14; bin 2
SW, 32, signed width of the Goertzel state registers s1/s2
PSHIFT, 8, arithmetic right shift applied to snapshot states before power computation
THRESHOLD, 48'd1000000, minimum bin power (strictly greater) for detection

Ports:
clk  in  1  sample clock, 100 MHz
rst  in  1  synchronous, active-high reset
is14_sample  in  14  signed two's-complement ADC sample
i_sample_valid  in  1  sample qualifier; a sample is accepted on any clock edge where this is high
o2_tone  out  2  winning bin index: 0=k1, 1=k5, 2=k10 (3 never driven)
o_detect  out  1  winning bin power > THRESHOLD
o_result_valid  out  1  one-cycle strobe; o2_tone/o_detect are updated in the same cycle

Behaviour:
- Reset (rst high at a clock edge):
  - All state registers, snapshots and the sample counter are set to 0. FSM goes to ACC.
  - o2_tone=0, o_detect=0, o_result_valid=0.
  - Reset mid-block discards partial accumulation. Reset during the power phase aborts it with no strobe.
- Accumulation (every accepted sample, all three bins in the same cycle):
  - s0 = x + ((COEFk·s1) >>> 14) - s2; then s2 <= s1, s1 <= s0.
  - x is sign-extended to SW. The product is SW+18 bits. Results wrap mod 2^SW; no saturation.
  - Sample counter counts 0..N_SAMPLES-1 and wraps.
- End of block:
  - On the edge that accepts sample N_SAMPLES-1, the updated s1/s2 of each bin are copied to snapshot registers.
  - Live states are cleared to 0 on that same edge, so the next sample starts a new block with no gap.
  - Samples keep being accepted during the power phase.
- Power phase (FSM PWR0 → PWR1 → PWR2 → DECIDE, one cycle each, one shared multiplier set):
  - a = snap_s1 >>> PSHIFT, b = snap_s2 >>> PSHIFT.
  - Pk = a² + b² - ((COEFk·a·b) >>> 14). Held as 48-bit signed; a negative result (rounding) is clamped to 0.
- DECIDE:
  - Winner = argmax Pk. Ties go to the lowest index.
  - o_detect = (Pwinner > THRESHOLD).
  - o2_tone/o_detect are registered, and o_result_valid is pulsed high for exactly one cycle.
  - FSM returns to ACC (the ACC accumulation path runs independently of the FSM).
- Latency: o_result_valid is high in the 4th cycle after the edge accepting the last sample of a block, i.e. after edges T+1..T+4 with the strobe visible after T+4.
- Outputs hold their values between strobes.
- Block overrun is impossible because N_SAMPLES ≥ 8 exceeds the 4-cycle power phase. Implementations must not stall sample acceptance.
- i_sample_valid low: no state or counter change; the power phase still proceeds.

Test Plan:
- Tone k=5 test:
  - Reset, then 64 samples round(8191·sin(2π·5n/64)) with valid every cycle.
  - Expect o_result_valid exactly once, 4 cycles after sample 63; o2_tone=1, o_detect=1, P1 ≫ P0, P2.
- Tone sweep test:
  - Repeat with k=1 then k=10 as back-to-back blocks, valid continuous.
  - Expect strobes 64 cycles apart: o2_tone=0, then 2; o_detect=1 both times; no sample lost at block boundaries.
- Silence test:
  - 64 zero samples.
  - Expect all Pk=0 → o2_tone=0 (tie rule), o_detect=0, one strobe.
- Gapped-valid test:
  - k=10 tone with i_sample_valid toggling 1,0,1,0 (128 cycles for 64 samples).
  - Expect the result identical to continuous input: o2_tone=2, o_detect=1, strobe 4 cycles after the 64th accepted sample.
- Reset mid-block:
  - 30 samples of k=5, assert rst for one cycle, then 64 samples of k=1.
  - Expect no strobe from the aborted block; the first strobe reports o2_tone=0, o_detect=1.
- Reset during power phase:
  - Assert rst 2 cycles after sample 63.
  - Expect no o_result_valid; outputs 0; the next full block is reported normally.
